// File: rtl/ru_mem_requester_if.sv
// Core/RAM signal bundle for the memory requester.
// master = requester side, slave = core + RAM side.
interface ru_mem_requester_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write_enable;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  modport master (
    input  req_valid, req_write, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  mem_rdata, mem_busy,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_write_enable
  );

  modport slave (
    output req_valid, req_write, req_size,
    output req_unsigned, req_addr, req_wdata,
    output mem_rdata, mem_busy,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_write_enable
  );
endinterface

// File: rtl/ru_mem_requester.sv
// Load/store unit driving a word-only RAM (RMW for sub-word stores).
// Define RU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module ru_mem_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic nRst,
  ru_mem_requester_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD, RMW_RD, WR, RESP
  } state_e;

  localparam logic [7:0] CNT_LAST =
    8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [15:0] wdata_q;
  logic [7:0]  cnt_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;

  logic mis;
  logic sub;
  logic timeout;

`ifdef RU_MISALIGN_TRAP_EN
  assign mis =
    (bus.req_size == 2'd1 && bus.req_addr[0]) ||
    (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign sub     = ~bus.req_size[1];
  assign timeout = (cnt_q == CNT_LAST);

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [1:0]  sz,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    unique case (1'b1)
      sz == 2'd0: load_ext = {{24{~uns & b[7]}}, b};
      sz == 2'd1: load_ext = {{16{~uns & h[15]}}, h};
      default:    load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [15:0] d,
    input logic [1:0]  off,
    input logic [1:0]  sz
  );
    merge = w;
    if (sz == 2'd0)
      merge[{off, 3'b000} +: 8] = d[7:0];
    else
      merge[{off[1], 4'b0000} +: 16] = d;
  endfunction

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= IDLE;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.req_valid) begin
          off_q       <= bus.req_addr[1:0];
          size_q      <= bus.req_size;
          uns_q       <= bus.req_unsigned;
          wdata_q     <= bus.req_wdata[15:0];
          cnt_q       <= '0;
          req_ready_q <= 1'b0;
          unique case (1'b1)
            mis: begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end
            !mis && !bus.req_write: begin
              state_q    <= RD;
              mem_addr_q <= {bus.req_addr[31:2], 2'b00};
            end
            !mis && bus.req_write && sub: begin
              state_q    <= RMW_RD;
              mem_addr_q <= {bus.req_addr[31:2], 2'b00};
            end
            default: begin
              state_q     <= WR;
              mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
              mem_wdata_q <= bus.req_wdata;
              mem_we_q    <= 1'b1;
            end
          endcase
        end
        RESP: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        // RD, RMW_RD, WR: hold everything while the RAM is busy
        default: if (bus.mem_busy) begin
          if (timeout) begin
            state_q      <= RESP;
            cnt_q        <= '0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end else begin
          cnt_q <= '0;
          if (state_q == RD) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_ext(
              bus.mem_rdata, off_q, size_q, uns_q);
          end else if (state_q == RMW_RD) begin
            state_q     <= WR;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merge(
              bus.mem_rdata, wdata_q, off_q, size_q);
          end else begin
            state_q      <= RESP;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready_q;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_err         = resp_err_q;
  assign bus.resp_rdata       = resp_rdata_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_wdata        = mem_wdata_q;
  assign bus.mem_write_enable = mem_we_q;

endmodule

// File: tb/tb_ru_mem_requester.sv
// Bench for ru_mem_requester: vector table, RAM model
// with busy injection, response scoreboard, reset abort.
module tb_ru_mem_requester;

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wd;
    int          busy;
    logic [31:0] rd;
    bit          err;
    int          lat;
    int          nwr;
    logic [31:0] mwd;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    bit          err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic nRst;
  bit   preload;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] ram [64];
  int          wr_cnt = 0;
  logic [31:0] last_wa;
  logic [31:0] last_wd;

  exp_t sb[$];
  vec_t tbl[$];

  ru_mem_requester_if bus();

  ru_mem_requester #(.TIMEOUT_CYCLES(4)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = ram[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
      ram[2] <= 32'h80017FFF;
      ram[8] <= 32'h11223344;
    end else if (bus.mem_write_enable && !bus.mem_busy) begin
      ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= bus.mem_addr;
      last_wd <= bus.mem_wdata;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string nm);
    int w0;
    int lat;
    bit got;
    logic [31:0] sa;
    logic [31:0] sd;
    exp_t e;
    w0 = wr_cnt;
    bus.req_valid    = 1'b1;
    bus.req_write    = v.wr;
    bus.req_size     = v.sz;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wd;
    chk({nm, ".ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    sb.push_back('{v.rd, v.err, v.lat});
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_write = 1'($urandom);
    bus.mem_busy  = (v.busy > 0);
    lat = 0;
    got = 1'b0;
    sa  = '0;
    sd  = '0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        sa = bus.mem_addr;
        sd = bus.mem_wdata;
      end
      if (bus.resp_valid) begin
        got = 1'b1;
        bus.mem_busy = 1'b0;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s.sb: response with empty queue", nm);
        end else begin
          e = sb.pop_front();
          chk({nm, ".rdata"}, bus.resp_rdata, e.rd);
          chk({nm, ".err"}, 32'(bus.resp_err), 32'(e.err));
          if (e.lat > 0)
            chk({nm, ".lat"}, 32'(lat), 32'(e.lat));
        end
      end else if (v.busy > 0 && lat >= 2 &&
                   lat <= v.busy + 1) begin
        chk({nm, ".hold_addr"}, bus.mem_addr, sa);
        chk({nm, ".hold_wd"}, bus.mem_wdata, sd);
      end
      if (lat == v.busy + 1) bus.mem_busy = 1'b0;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.resp: no resp_valid in 40 cycles", nm);
      bus.mem_busy = 1'b0;
      if (sb.size() > 0) void'(sb.pop_front());
    end
    chk({nm, ".nwr"}, 32'(wr_cnt - w0), 32'(v.nwr));
    if (v.nwr > 0) begin
      chk({nm, ".waddr"}, last_wa, {v.addr[31:2], 2'b00});
      chk({nm, ".wdata"}, last_wd, v.mwd);
    end
    @(negedge clk);
    chk({nm, ".pulse"}, 32'(bus.resp_valid), 32'd0);
    chk({nm, ".idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] saved;
    int w0;

    // wr sz uns addr wd busy | rd err lat nwr mwd
    tbl.push_back('{1, 2, 0, 32'h10, 32'hDEADBEEF, 0,
                    32'h0, 0, 2, 1, 32'hDEADBEEF});
    tbl.push_back('{0, 2, 0, 32'h10, 32'h0, 0,
                    32'hDEADBEEF, 0, 2, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 32'h22, 32'h123456AA, 0,
                    32'h0, 0, 3, 1, 32'h11AA3344});
    tbl.push_back('{0, 0, 0, 32'h22, 32'h0, 0,
                    32'hFFFFFFAA, 0, 2, 0, 32'h0});
    tbl.push_back('{0, 0, 1, 32'h22, 32'h0, 0,
                    32'h000000AA, 0, 2, 0, 32'h0});
    tbl.push_back('{0, 1, 0, 32'hA, 32'h0, 0,
                    32'hFFFF8001, 0, 2, 0, 32'h0});
    tbl.push_back('{0, 1, 0, 32'h8, 32'h0, 0,
                    32'h00007FFF, 0, 2, 0, 32'h0});
    tbl.push_back('{0, 1, 1, 32'hA, 32'h0, 0,
                    32'h00008001, 0, 2, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 32'h22, 32'h1234BEEF, 0,
                    32'h0, 0, 3, 1, 32'hBEEF3344});
    tbl.push_back('{0, 3, 0, 32'h20, 32'h0, 0,
                    32'hBEEF3344, 0, 2, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 32'h13, 32'h00000055, 0,
                    32'h0, 0, 3, 1, 32'h55ADBEEF});
    tbl.push_back('{0, 0, 0, 32'h11, 32'h0, 0,
                    32'hFFFFFFBE, 0, 2, 0, 32'h0});
    tbl.push_back('{1, 2, 0, 32'h30, 32'hCAFEF00D, 3,
                    32'h0, 0, 5, 1, 32'hCAFEF00D});
    tbl.push_back('{0, 2, 0, 32'h30, 32'h0, 2,
                    32'hCAFEF00D, 0, 4, 0, 32'h0});
    tbl.push_back('{0, 2, 0, 32'h30, 32'h0, 100,
                    32'h0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 2, 0, 32'h30, 32'h0, 0,
                    32'hCAFEF00D, 0, 2, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 32'h30, 32'h00000077, 1,
                    32'h0, 0, 4, 1, 32'hCAFEF077});
`ifdef RU_MISALIGN_TRAP_EN
    tbl.push_back('{0, 2, 0, 32'h13, 32'h0, 0,
                    32'h0, 1, 1, 0, 32'h0});
    tbl.push_back('{0, 1, 0, 32'hB, 32'h0, 0,
                    32'h0, 1, 1, 0, 32'h0});
    tbl.push_back('{1, 2, 0, 32'h31, 32'h0BADF00D, 0,
                    32'h0, 1, 1, 0, 32'h0});
`else
    tbl.push_back('{0, 2, 0, 32'h13, 32'h0, 0,
                    32'h55ADBEEF, 0, 2, 0, 32'h0});
    tbl.push_back('{0, 1, 0, 32'hB, 32'h0, 0,
                    32'hFFFF8001, 0, 2, 0, 32'h0});
    tbl.push_back('{1, 2, 0, 32'h31, 32'h0BADF00D, 0,
                    32'h0, 0, 2, 1, 32'h0BADF00D});
`endif

    nRst             = 1'b0;
    preload          = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.mem_busy     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", 32'(bus.req_ready), 32'd1);
    chk("rst.valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.err", 32'(bus.resp_err), 32'd0);
    chk("rst.rdata", bus.resp_rdata, 32'd0);
    chk("rst.addr", bus.mem_addr, 32'd0);
    chk("rst.wdata", bus.mem_wdata, 32'd0);
    chk("rst.we", 32'(bus.mem_write_enable), 32'd0);
    preload = 1'b0;
    nRst    = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++)
      run(tbl[i], $sformatf("v%0d", i));

    // reset while the RMW write is stalled in WR
    saved = ram[8];
    w0    = wr_cnt;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h21;
    bus.req_wdata    = 32'h99;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 bus.mem_busy = 1'b1;
    @(negedge clk);
    chk("rrst.we_wr", 32'(bus.mem_write_enable), 32'd1);
    chk("rrst.wd_wr", bus.mem_wdata, 32'hBEEF9944);
    nRst = 1'b0;
    #1;
    chk("rrst.we", 32'(bus.mem_write_enable), 32'd0);
    chk("rrst.ready", 32'(bus.req_ready), 32'd1);
    chk("rrst.valid", 32'(bus.resp_valid), 32'd0);
    bus.mem_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    chk("rrst.ram", ram[8], saved);
    chk("rrst.nwr", 32'(wr_cnt - w0), 32'd0);
    chk("rrst.ready2", 32'(bus.req_ready), 32'd1);
    run('{0, 2, 0, 32'h20, 32'h0, 0,
          32'hBEEF3344, 0, 2, 0, 32'h0}, "post_rst");
    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ru_mem_requester.md
Name: ru_mem_requester

Overview:
- Initiator-side memory access unit for the single-cycle RISC-V core.
- Drives the word-addressed data RAM port (addr, write data, write enable, busy, read data) on behalf of core load/store instructions.
- Converts byte, halfword and word loads/stores into word-only RAM transactions: sub-word stores use read-modify-write; loads are sign/zero-extended.
- Stalls the core through a ready/valid handshake while the RAM reports busy.

Parameters:
- TIMEOUT_CYCLES, 255: consecutive mem_busy=1 cycles in one access state before aborting with resp_err. Range 1..255; counter is 8 bits.

Ports:
- clk  in  1  system clock, rising edge
- nRst  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  requester can accept a request; high only in IDLE
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal and treated as word
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid: timeout or misaligned access
- mem_addr  out  32  word-aligned RAM address {a[31:2],2'b00}
- mem_wdata  out  32  RAM write data
- mem_write_enable  out  1  RAM write strobe
- mem_rdata  in  32  RAM combinational read data for mem_addr
- mem_busy  in  1  RAM cannot accept or complete an access this cycle

Behaviour:
- Reset (async, nRst=0): state=IDLE. req_ready=1. resp_valid=0, resp_err=0, resp_rdata=0. mem_addr=0, mem_wdata=0, mem_write_enable=0. Timeout counter=0. Reset mid-access abandons it; no write is issued afterwards.
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE: on req_valid&req_ready, register addr, size, write, unsigned and wdata. Next state:
  - load -> RD
  - word store -> WR
  - byte or half store -> RMW_RD
- RD / RMW_RD:
  - mem_addr driven from the registered address; mem_write_enable=0.
  - On a cycle with mem_busy=0, capture mem_rdata. RD -> RESP; RMW_RD -> WR.
- WR:
  - mem_write_enable=1 and mem_wdata held stable.
  - Word store: mem_wdata = registered wdata.
  - Sub-word store: mem_wdata = captured word with lane replaced. Byte lane = addr[1:0]; half lane = addr[1].
  - The write commits on the first rising edge with mem_busy=0; state -> RESP.
  - mem_write_enable may stay high during busy cycles; the RAM ignores it then.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - Loads: resp_rdata = selected byte/half/word, extended per req_unsigned.
- mem_busy=1 in any access state: hold state, mem_addr, mem_wdata and mem_write_enable; increment the counter.
- Counter reaches TIMEOUT_CYCLES: go to RESP with resp_err=1 and resp_rdata=0; no write is issued. The counter clears on every state change.
- Latency with mem_busy=0:
  - Load and word store: resp_valid 2 cycles after the acceptance edge.
  - Sub-word store: 3 cycles after the acceptance edge.
  - Each busy cycle adds 1.
- req_ready=0 outside IDLE. req_* inputs are ignored while not in IDLE.
- Back-to-back: a new request is accepted in the IDLE cycle right after RESP; RESP does not overlap acceptance.

Optional Feature:
- Macro: RU_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE -> RESP.
  - resp_err=1, resp_rdata=0, with no RAM read or write.
- Undefined:
  - Misaligned offsets are truncated: half uses addr[1] only, word ignores addr[1:0].
  - resp_err asserts only on timeout.

Test Plan:
- Word store then load, busy=0: store 0xDEADBEEF @0x10 -> mem_write_enable for one cycle with mem_addr=0x10; load @0x10 -> resp_rdata=0xDEADBEEF 2 cycles after acceptance.
- Byte store RMW: RAM[0x20]=0x11223344, store byte 0xAA @0x22 -> mem_wdata=0x11AA3344; signed byte load @0x22 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Half load: RAM[0x8]=0x80017FFF; signed half @0xA -> 0xFFFF8001; signed half @0x8 -> 0x00007FFF.
- Busy stall: mem_busy=1 for 3 cycles during WR -> outputs held stable, one write only, resp_valid 5 cycles after acceptance.
- Timeout, TIMEOUT_CYCLES=4, mem_busy stuck at 1 on a load -> resp_valid with resp_err=1 and resp_rdata=0; next request is accepted normally.
- Reset mid-RMW (nRst low in WR) -> mem_write_enable=0 immediately, RAM unchanged, req_ready=1 after release.
- With RU_MISALIGN_TRAP_EN: word load @0x13 -> resp_err=1, no RAM access. Without it: returns RAM[0x10].
